// File: rtl/stage3_fast_nm_encoder.sv
// FAST-style normal-message encoder with an internal copy-operator dictionary.
// Two-stage valid/ready pipeline: compare + dictionary update, then pack.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        message present on in_fields/in_tail
//   in_ready        block accepts a message this cycle
//   in_fields       NUM_FIELDS compared fields, field 0 in the MSBs
//   in_tail         always-transmitted tail field
//   dict_clear      invalidate dictionary; only honoured on an accept
//   out_valid       encoded message present
//   out_ready       downstream accepts
//   out_msg         {pmap, missed fields, tail, zero pad}, left-justified
//   out_len         number of valid bytes in out_msg
//   dict_hits       saturating count of fields omitted since reset

module stage3_fast_nm_encoder #(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 8,
    parameter int TAIL_W     = 32,
    parameter int PMAP_W     = 16,
    parameter int OUT_W      = 344,
    parameter int LEN_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0] in_fields,
    input  logic [TAIL_W-1:0]             in_tail,
    input  logic                          dict_clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_msg,
    output logic [LEN_W-1:0]              out_len,
    output logic [15:0]                   dict_hits
);

    localparam int FB = NUM_FIELDS * FIELD_W;

    logic [FIELD_W-1:0]    dict [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] dict_valid;
    logic                  ready_en;

    logic                  s1_valid;
    logic [PMAP_W-1:0]     s1_pmap;
    logic [FB-1:0]         s1_fields;
    logic [TAIL_W-1:0]     s1_tail;
    logic [NUM_FIELDS-1:0] s1_miss;
    logic [15:0]           s1_nmiss;

    logic                  s1_adv;
    logic                  accept;
    logic [NUM_FIELDS-1:0] hit;
    logic [15:0]           hit_cnt;
    logic [15:0]           miss_cnt;
    logic [PMAP_W-1:0]     pmap;
    logic [16:0]           hits_sum;
    logic [OUT_W-1:0]      acc;
    logic [OUT_W-1:0]      pack_msg;
    logic [LEN_W-1:0]      pack_len;
    int                    pad;
    int                    len_i;

    // ready_en keeps in_ready low until the first clock after reset release.
    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = ready_en && (!s1_valid || s1_adv);
    assign accept   = in_valid && in_ready;

    always_comb begin
        hit     = '0;
        hit_cnt = '0;
        pmap    = '0;
        pmap[PMAP_W-1] = 1'b1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            hit[i] = dict_valid[i] && !dict_clear &&
                     (dict[i] == in_fields[FB-1-i*FIELD_W -: FIELD_W]);
            pmap[PMAP_W-2-i] = hit[i];
            hit_cnt = hit_cnt + 16'(hit[i]);
        end
        miss_cnt = 16'(NUM_FIELDS) - hit_cnt;
        hits_sum = {1'b0, dict_hits} + {1'b0, hit_cnt};
    end

    // Shift-accumulate the present fields behind the pmap, then the tail,
    // and finally left-justify by the unused width.
    always_comb begin
        acc = OUT_W'(s1_pmap);
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (s1_miss[i]) begin
                acc = (acc << FIELD_W) |
                      OUT_W'(s1_fields[FB-1-i*FIELD_W -: FIELD_W]);
            end
        end
        acc = (acc << TAIL_W) | OUT_W'(s1_tail);
        pad = OUT_W - PMAP_W - TAIL_W - int'(s1_nmiss) * FIELD_W;
        pack_msg = acc << pad;
        len_i = PMAP_W / 8 + TAIL_W / 8 + (FIELD_W / 8) * int'(s1_nmiss);
        pack_len = LEN_W'(len_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            dict_valid <= '0;
            dict_hits  <= '0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                dict[i] <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                dict_valid <= '1;
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    dict[i] <= in_fields[FB-1-i*FIELD_W -: FIELD_W];
                end
                dict_hits <= hits_sum[16] ? 16'hFFFF : hits_sum[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_pmap   <= '0;
            s1_fields <= '0;
            s1_tail   <= '0;
            s1_miss   <= '0;
            s1_nmiss  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_pmap   <= pmap;
                s1_fields <= in_fields;
                s1_tail   <= in_tail;
                s1_miss   <= ~hit;
                s1_nmiss  <= miss_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_msg   <= '0;
            out_len   <= '0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_msg <= pack_msg;
                out_len <= pack_len;
            end
        end
    end

endmodule

// File: tb/tb_stage3_fast_nm_encoder.sv
// Scoreboard bench for stage3_fast_nm_encoder.
// Directed vectors with hand-computed encodings.

module tb_stage3_fast_nm_encoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [23:0]  in_fields;
    logic [31:0]  in_tail;
    logic         dict_clear;
    logic         out_valid;
    logic         out_ready;
    logic [343:0] out_msg;
    logic [7:0]   out_len;
    logic [15:0]  dict_hits;

    typedef struct packed {
        logic [343:0] msg;
        logic [7:0]   len;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    stage3_fast_nm_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fields  (in_fields),
        .in_tail    (in_tail),
        .dict_clear (dict_clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_msg    (out_msg),
        .out_len    (out_len),
        .dict_hits  (dict_hits)
    );

    // Monitor: while an output is presented it must equal the queue head;
    // the head is retired only on a completed handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out msg=%h len=%0d", out_msg, out_len);
            end else begin
                if (out_msg !== sbq[0].msg || out_len !== sbq[0].len) begin
                    n_fail++;
                    $display("FAIL out_msg got=%h/%0d exp=%h/%0d",
                             out_msg, out_len, sbq[0].msg, sbq[0].len);
                end
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send(input logic [23:0] f, input logic [31:0] t,
                        input logic clr, input logic [343:0] em,
                        input logic [7:0] el, input logic [15:0] eh);
        int n;
        exp_t e;
        @(negedge clk);
        in_valid   = 1'b1;
        in_fields  = f;
        in_tail    = t;
        dict_clear = clr;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout fields=%h", f);
        end
        e.msg = em;
        e.len = el;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        dict_clear = 1'b0;
        check("dict_hits", 32'(dict_hits), 32'(eh));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout left=%0d exp=0", sbq.size());
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_fields  = '0;
        in_tail    = '0;
        dict_clear = 1'b0;
        out_ready  = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_len", 32'(out_len), 32'd0);
        check("rst_out_msg_zero", 32'(out_msg == '0), 32'd1);
        check("rst_dict_hits", 32'(dict_hits), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1-3: basic misses, back-to-back hits, partial hits
        send(24'hA1B2C3, 32'hDEADBEEF, 1'b0,
             {16'h8000, 24'hA1B2C3, 32'hDEADBEEF, 272'h0}, 8'd9, 16'd0);
        send(24'hA1B2C3, 32'h00000001, 1'b0,
             {16'hF000, 32'h00000001, 296'h0}, 8'd6, 16'd3);
        send(24'hA177C3, 32'h12345678, 1'b0,
             {16'hD000, 8'h77, 32'h12345678, 288'h0}, 8'd7, 16'd5);
        send(24'hA17755, 32'h0000000A, 1'b0,
             {16'hE000, 8'h55, 32'h0000000A, 288'h0}, 8'd7, 16'd7);
        drain();

        // 4: backpressure with four offered messages
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                send(24'hA17755, 32'h1, 1'b0,
                     {16'hF000, 32'h1, 296'h0}, 8'd6, 16'd10);
                send(24'h117755, 32'h2, 1'b0,
                     {16'hB000, 8'h11, 32'h2, 288'h0}, 8'd7, 16'd12);
                send(24'h112255, 32'h3, 1'b0,
                     {16'hD000, 8'h22, 32'h3, 288'h0}, 8'd7, 16'd14);
                send(24'h112233, 32'h4, 1'b0,
                     {16'hE000, 8'h33, 32'h4, 288'h0}, 8'd7, 16'd16);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                check("stall_in_ready", 32'(in_ready), 32'd0);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // 5: dict_clear forces misses, then dictionary hits again
        send(24'hA177C3, 32'h5, 1'b0,
             {16'h8000, 24'hA177C3, 32'h5, 272'h0}, 8'd9, 16'd16);
        send(24'hA177C3, 32'h6, 1'b1,
             {16'h8000, 24'hA177C3, 32'h6, 272'h0}, 8'd9, 16'd16);
        send(24'hA177C3, 32'h7, 1'b0,
             {16'hF000, 32'h7, 296'h0}, 8'd6, 16'd19);
        drain();

        // 6: async reset with both stages full
        out_ready = 1'b0;
        send(24'h010203, 32'h8, 1'b0,
             {16'h8000, 24'h010203, 32'h8, 272'h0}, 8'd9, 16'd19);
        send(24'h010203, 32'h9, 1'b0,
             {16'hF000, 32'h9, 296'h0}, 8'd6, 16'd22);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_dict_hits", 32'(dict_hits), 32'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(24'hA1B2C3, 32'hDEADBEEF, 1'b0,
             {16'h8000, 24'hA1B2C3, 32'hDEADBEEF, 272'h0}, 8'd9, 16'd0);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stage3_fast_nm_encoder.md
Name: stage3_fast_nm_encoder

Overview:
- Parametrised, pipelined FAST-style encoder for normal-message (NM) fields.
- Compares NUM_FIELDS header fields of each message against a per-field copy-operator dictionary. Emits a presence map, the changed fields only, the untouched tail field and a byte length.
- Unlike the stage-3 combinational encoder, the dictionary is held and updated internally, and the block uses a valid/ready stream with backpressure.
- Sits between the stage-2 message parser and the stage-4 output packer.

Parameters:
NUM_FIELDS, 3, number of dictionary-compared header fields (1..PMAP_W-1)
FIELD_W, 8, width of each compared field in bits (multiple of 8)
TAIL_W, 32, width of the always-sent tail field (BSN) in bits (multiple of 8)
PMAP_W, 16, presence-map width in bits (multiple of 8)
OUT_W, 344, output vector width in bits; must be >= PMAP_W+NUM_FIELDS*FIELD_W+TAIL_W
LEN_W, 8, width of byte-length output

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  message present
in_ready  output  1  block accepts message this cycle
in_fields  input  NUM_FIELDS*FIELD_W  compared fields; field 0 in the MSBs
in_tail  input  TAIL_W  tail field, always transmitted
dict_clear  input  1  invalidate dictionary (block boundary); sampled only with in_valid&&in_ready
out_valid  output  1  encoded message present
out_ready  input  1  downstream accepts
out_msg  output  OUT_W  {pmap, present fields, tail, zero pad}, left-justified
out_len  output  LEN_W  valid bytes in out_msg
dict_hits  output  16  count of fields omitted since reset, saturating

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_msg=0, out_len=0, dict_hits=0.
  - All dictionary entries and dict-valid flags are cleared; pipeline stages are empty.
  - in_ready is 1 from the first clock after release.
- Accept: occurs when in_valid&&in_ready. Compare, dictionary update and stage-1 load all happen at that clock edge.
- Compare: field i is a hit when dict_valid[i] && dict[i]==field i && !dict_clear.
- Dictionary update on accept:
  - dict[i] <= field i and dict_valid[i] <= 1 for every field, hit or miss.
  - dict_clear on the accepting cycle forces all misses; the dictionary is then loaded with this message.
  - The next accepted message, even back-to-back, compares against the updated values; no stale compare is allowed.
- Presence map:
  - pmap[PMAP_W-1]=1 (stop bit).
  - pmap[PMAP_W-2-i]=hit_i for i=0..NUM_FIELDS-1.
  - Remaining low bits are 0.
- Packing: missed fields are concatenated in index order (field 0 first) immediately after the pmap, then the tail, then zero padding to OUT_W. No gaps.
- out_len = PMAP_W/8 + TAIL_W/8 + (FIELD_W/8)*(NUM_FIELDS - hits). Computed at LEN_W; no overflow is permitted by parameter choice.
- Pipeline:
  - Stage 1 registers the pmap, fields and miss count.
  - Stage 2 (output register) holds the packed vector and length.
  - Latency from accept to out_valid is 2 cycles; throughput is 1 message per cycle.
- Handshake:
  - A stage advances when it is empty or the next stage advances.
  - in_ready = !s1_valid || s1_adv; s1_adv = !out_valid || out_ready.
  - out_msg and out_len stay stable while out_valid && !out_ready.
  - in_ready is not combinationally dependent on in_valid.
- dict_hits: increments by the hit count on each accept and saturates at 0xFFFF.
- dict_clear without in_valid has no effect.

Test Plan:
1. Defaults; after reset, accept fields A1,B2,C3 with tail DEADBEEF -> 2 cycles later out_valid=1, out_msg[343:272]={8000,A1,B2,C3,DEADBEEF} with the rest 0, out_len=9, dict_hits=0.
2. Next cycle, fields A1,B2,C3 with tail 00000001 -> pmap F000, out_msg[343:296]={F000,00000001}, out_len=6, dict_hits=3. Back-to-back compare must hit.
3. Fields A1,77,C3 with tail 12345678 after test 2 -> pmap D000, out_msg[343:288]={D000,77,12345678}, out_len=7. Then A1,77,55 -> pmap E000, field 55 sent, out_len=7.
4. out_ready=0 for 4 cycles while 4 messages are offered -> in_ready falls after 2 accepts, out_msg stable, no loss or duplication. After release, the outputs appear in order with pmaps consistent with the accepted sequence.
5. dict_clear=1 with an A1,77,C3 accept whose dictionary would otherwise hit on all fields -> pmap 8000, out_len=9. The following A1,77,C3 gives pmap F000.
6. Assert rst_n mid-stream with both stages full -> out_valid=0 immediately (async). The first message after reset is encoded with pmap 8000 and dict_hits=0.
